// File: rtl/hash_result_scan.sv
// Scans NUM_NONCES consecutive hash words from memory, tracking the smallest word and
// the count of words below target. Optional macro SCAN_WRITEBACK_EN writes a 3-word summary.
module hash_result_scan #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] output_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic [8:0]  hit_count,
    output logic        found
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_READ,
`ifdef SCAN_WRITEBACK_EN
        S_WRITE,
`endif
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [8:0]  idx;
    logic [31:0] target_q;
    logic        last;
    logic        take;
    logic        hit;
    logic [31:0] nxt_best_hash;
    logic [7:0]  nxt_best_nonce;
    logic [8:0]  nxt_hits;

    assign mem_clk = clk;
    assign last    = (idx == 9'(NUM_NONCES - 1));

`ifdef SCAN_WRITEBACK_EN
    logic [1:0] wcnt;
`else
    logic unused_result_addr;
    assign unused_result_addr = ^result_addr;
    assign mem_we             = 1'b0;
    assign mem_write_data     = 32'd0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PRIME;
            S_PRIME: state_nxt = S_READ;
            S_READ:
                if (last) begin
`ifdef SCAN_WRITEBACK_EN
                    state_nxt = S_WRITE;
`else
                    state_nxt = S_DONE;
`endif
                end
`ifdef SCAN_WRITEBACK_EN
            S_WRITE: if (wcnt == 2'd2) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Word k=0 is always taken; later words only on a strictly smaller value so ties keep the lower index
    always_comb begin
        take           = (idx == 9'd0) || (mem_read_data < best_hash);
        hit            = (mem_read_data < target_q);
        nxt_best_hash  = take ? mem_read_data : best_hash;
        nxt_best_nonce = take ? idx[7:0] : best_nonce;
        nxt_hits       = hit_count + {8'd0, hit};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done       <= 1'b0;
            mem_addr   <= 16'd0;
            best_nonce <= 8'd0;
            best_hash  <= 32'd0;
            hit_count  <= 9'd0;
            found      <= 1'b0;
            target_q   <= 32'd0;
            idx        <= 9'd0;
`ifdef SCAN_WRITEBACK_EN
            mem_we         <= 1'b0;
            mem_write_data <= 32'd0;
            wcnt           <= 2'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr   <= output_addr;
                        target_q   <= target;
                        done       <= 1'b0;
                        best_hash  <= 32'hFFFF_FFFF;
                        best_nonce <= 8'd0;
                        hit_count  <= 9'd0;
                        found      <= 1'b0;
                        idx        <= 9'd0;
                    end
                end
                S_PRIME: mem_addr <= mem_addr + 16'd1;
                S_READ: begin
                    best_hash  <= nxt_best_hash;
                    best_nonce <= nxt_best_nonce;
                    hit_count  <= nxt_hits;
                    found      <= (nxt_hits != 9'd0);
                    idx        <= idx + 9'd1;
                    mem_addr   <= mem_addr + 16'd1;
                    if (last) begin
`ifdef SCAN_WRITEBACK_EN
                        mem_we         <= 1'b1;
                        mem_addr       <= result_addr;
                        mem_write_data <= {24'd0, nxt_best_nonce};
                        wcnt           <= 2'd0;
`else
                        done <= 1'b1;
`endif
                    end
                end
`ifdef SCAN_WRITEBACK_EN
                S_WRITE: begin
                    wcnt <= wcnt + 2'd1;
                    case (wcnt)
                        2'd0: begin
                            mem_addr       <= mem_addr + 16'd1;
                            mem_write_data <= best_hash;
                        end
                        2'd1: begin
                            mem_addr       <= mem_addr + 16'd1;
                            mem_write_data <= {23'd0, hit_count};
                        end
                        default: begin
                            mem_we <= 1'b0;
                            done   <= 1'b1;
                        end
                    endcase
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_result_scan.sv
// Scoreboard bench for hash_result_scan: a synchronous memory model feeds the DUT,
// expected summaries are queued at start and compared when done rises.
module tb_hash_result_scan;
    localparam int N = 16;
    localparam logic [15:0] RES = 16'h0100;
`ifdef SCAN_WRITEBACK_EN
    localparam int LAT = N + 4;
`else
    localparam int LAT = N + 1;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] output_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;
    logic [8:0]  hit_count;
    logic        found;

    typedef struct packed {
        logic [7:0]  nonce;
        logic [31:0] hash;
        logic [8:0]  hits;
        logic        fnd;
    } exp_t;

    logic [31:0] words [0:65535];
    exp_t        exp_q[$];
    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int n_vec = 0;
    int n_err = 0;

    hash_result_scan #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .output_addr(output_addr),
        .result_addr(result_addr), .target(target), .done(done), .mem_clk(mem_clk),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .best_nonce(best_nonce), .best_hash(best_hash),
        .hit_count(hit_count), .found(found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_read_data <= words[mem_addr];
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_write_data);
        end
    end

    function automatic exp_t model(input logic [15:0] base, input logic [31:0] tgt);
        exp_t e;
        e.hash  = words[base];
        e.nonce = 8'd0;
        e.hits  = 9'd0;
        for (int i = 0; i < N; i++) begin
            logic [31:0] w;
            w = words[16'(base + i)];
            if (w < e.hash) begin
                e.hash  = w;
                e.nonce = 8'(i);
            end
            if (w < tgt) e.hits = e.hits + 9'd1;
        end
        e.fnd = (e.hits != 9'd0);
        return e;
    endfunction

    task automatic run_scan(input string tag, input logic [15:0] base, input logic [31:0] tgt,
                            input int glitch_edge);
        exp_t ex;
        int   w0;
        int   lat;
        exp_q.push_back(model(base, tgt));
        output_addr = base;
        target      = tgt;
        result_addr = RES;
        w0          = wr_addr_q.size();
        lat         = -1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (mem_addr !== base || done !== 1'b0 || best_hash !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL %s accept: addr=%h done=%b best_hash=%h expected addr=%h done=0 best_hash=ffffffff",
                     tag, mem_addr, done, best_hash, base);
        end
        for (int e = 1; e <= LAT + 10; e++) begin
            @(negedge clk); start = (e == glitch_edge);
            @(posedge clk); #1;
            if (e < 4) begin
                n_vec++;
                if (mem_addr !== 16'(base + e)) begin
                    n_err++;
                    $display("FAIL %s addr_edge%0d: got %h expected %h", tag, e, mem_addr, 16'(base + e));
                end
            end
            if (done) begin
                lat = e;
                break;
            end
        end
        @(negedge clk); start = 1'b0;
        n_vec++;
        if (lat !== LAT) begin
            n_err++;
            $display("FAIL %s done_latency: got %0d expected %0d", tag, lat, LAT);
        end
        ex = exp_q.pop_front();
        n_vec++;
        if (best_nonce !== ex.nonce) begin
            n_err++;
            $display("FAIL %s best_nonce: got %0d expected %0d", tag, best_nonce, ex.nonce);
        end
        n_vec++;
        if (best_hash !== ex.hash) begin
            n_err++;
            $display("FAIL %s best_hash: got %h expected %h", tag, best_hash, ex.hash);
        end
        n_vec++;
        if (hit_count !== ex.hits || found !== ex.fnd) begin
            n_err++;
            $display("FAIL %s hits: got %0d/%b expected %0d/%b", tag, hit_count, found, ex.hits, ex.fnd);
        end
`ifdef SCAN_WRITEBACK_EN
        n_vec++;
        if (wr_addr_q.size() - w0 !== 3) begin
            n_err++;
            $display("FAIL %s write_count: got %0d expected 3", tag, wr_addr_q.size() - w0);
        end else begin
            logic [31:0] wd [3];
            wd[0] = {24'd0, ex.nonce};
            wd[1] = ex.hash;
            wd[2] = {23'd0, ex.hits};
            for (int j = 0; j < 3; j++) begin
                n_vec++;
                if (wr_addr_q[w0 + j] !== 16'(RES + j) || wr_data_q[w0 + j] !== wd[j]) begin
                    n_err++;
                    $display("FAIL %s write%0d: got %h@%h expected %h@%h", tag, j,
                             wr_data_q[w0 + j], wr_addr_q[w0 + j], wd[j], 16'(RES + j));
                end
            end
        end
`else
        n_vec++;
        if (wr_addr_q.size() - w0 !== 0) begin
            n_err++;
            $display("FAIL %s write_count: got %0d expected 0", tag, wr_addr_q.size() - w0);
        end
`endif
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if (done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'd0 || mem_write_data !== 32'd0 ||
            best_nonce !== 8'd0 || best_hash !== 32'd0 || hit_count !== 9'd0 || found !== 1'b0) begin
            n_err++;
            $display("FAIL %s: done=%b we=%b addr=%h wd=%h nonce=%h hash=%h hits=%h found=%b expected all 0",
                     tag, done, mem_we, mem_addr, mem_write_data, best_nonce, best_hash, hit_count, found);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        check_zero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_decreasing();
        for (int i = 0; i < N; i++) words[i] = 32'(100 - i);
        run_scan("decreasing", 16'h0000, 32'd90, 0);
        n_vec++;
        if (best_nonce !== 8'd15 || best_hash !== 32'd85 || hit_count !== 9'd5 || found !== 1'b1) begin
            n_err++;
            $display("FAIL decreasing_const: got %0d/%0d/%0d/%b expected 15/85/5/1",
                     best_nonce, best_hash, hit_count, found);
        end
    endtask

    task automatic test_ties();
        for (int i = 0; i < N; i++) words[16'h0200 + i] = 32'h7;
        run_scan("ties", 16'h0200, 32'd0, 0);
        n_vec++;
        if (best_nonce !== 8'd0 || hit_count !== 9'd0 || found !== 1'b0) begin
            n_err++;
            $display("FAIL ties_const: got %0d/%0d/%b expected 0/0/0", best_nonce, hit_count, found);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < N; i++) words[16'(16'hFFFE + i)] = 32'($urandom_range(0, 500));
        words[16'h0001] = 32'd3;
        run_scan("wrap", 16'hFFFE, 32'd250, 0);
    endtask

    task automatic test_min_at_three();
        for (int i = 0; i < N; i++) words[16'h0400 + i] = 32'(50 + i);
        words[16'h0403] = 32'h1;
        run_scan("min_at_three", 16'h0400, 32'd2, 0);
        n_vec++;
        if (best_nonce !== 8'd3 || best_hash !== 32'd1 || hit_count !== 9'd1) begin
            n_err++;
            $display("FAIL min_at_three_const: got %0d/%0d/%0d expected 3/1/1", best_nonce, best_hash, hit_count);
        end
    endtask

    task automatic test_start_during_read();
        for (int i = 0; i < N; i++) words[16'h0600 + i] = $urandom;
        run_scan("start_glitch", 16'h0600, 32'h8000_0000, 5);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            logic [15:0] b;
            b = 16'($urandom);
            for (int i = 0; i < N; i++) words[16'(b + i)] = 32'($urandom_range(0, 40));
            run_scan("random", b, 32'($urandom_range(0, 40)), 0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int w0;
        int seen;
        for (int i = 0; i < N; i++) words[16'h0800 + i] = 32'(1000 - 3 * i);
        output_addr = 16'h0800;
        target      = 32'd995;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset_n = 1'b0;
        w0 = wr_addr_q.size();
        #1;
        check_zero("reset_mid_scan");
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_vec++;
        if (seen !== 0 || wr_addr_q.size() !== w0) begin
            n_err++;
            $display("FAIL reset_abort: done_cycles=%0d writes=%0d expected 0/0", seen, wr_addr_q.size() - w0);
        end
        run_scan("after_reset", 16'h0800, 32'd995, 0);
    endtask

    task automatic test_back_to_back();
        logic d [0:63];
        exp_t ex;
        for (int i = 0; i < N; i++) words[16'h0A00 + i] = 32'((i * 37) % 23);
        output_addr = 16'h0A00;
        target      = 32'd10;
        exp_q.push_back(model(16'h0A00, 32'd10));
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 2 * LAT + 2; e++) begin
            @(posedge clk); #1;
            d[e] = done;
        end
        @(negedge clk); start = 1'b0;
        n_vec++;
        if (d[LAT-1] !== 1'b0 || d[LAT] !== 1'b1 || d[LAT+1] !== 1'b1 || d[LAT+2] !== 1'b0 ||
            d[2*LAT+1] !== 1'b0 || d[2*LAT+2] !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back_done: got %b%b%b%b%b%b expected 011001",
                     d[LAT-1], d[LAT], d[LAT+1], d[LAT+2], d[2*LAT+1], d[2*LAT+2]);
        end
        ex = exp_q.pop_front();
        n_vec++;
        if (best_nonce !== ex.nonce || best_hash !== ex.hash || hit_count !== ex.hits) begin
            n_err++;
            $display("FAIL back_to_back_result: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     best_nonce, best_hash, hit_count, ex.nonce, ex.hash, ex.hits);
        end
    endtask

    initial begin
        start       = 1'b0;
        output_addr = 16'd0;
        result_addr = RES;
        target      = 32'd0;
        for (int i = 0; i < 65536; i++) words[i] = 32'd0;
        test_reset();
        test_decreasing();
        test_ties();
        test_wrap();
        test_min_at_three();
        test_start_during_read();
        test_random();
        test_reset_mid_scan();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end
endmodule
